sprite_bank: RTL and testbench

Parametrised successor to the single-width bitmap store. Holds `2**SIZE` blocks of 16x16 pixels in an on-chip RAM and serves one pixel per clock to the sprite/background renderer. It supports widths of 1..`2**MAXW_LOG` blocks, horizontal and vertical mirroring, a transparency key, out-of-range masking and a runtime write port for loading bitmaps. Reads are fully pipelined with a valid flag so the renderer can align pixel data to its scan position.

---
 rtl/sprite_bank.sv | 146 ++++++++++++++
 tb/tb_sprite_bank.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sprite_bank
// Purpose  : Bitmap store of 2**SIZE blocks of 16x16 pixels serving one pixel
//            per clock to the renderer. Supports widths of 1..2**MAXW_LOG
//            blocks, horizontal/vertical mirroring, a transparency key,
//            out-of-range masking and a runtime write port.
// Ports    : clk, rst_n (async, active-low)
//            req_valid, addr, wlog, hflip, vflip, hpos, vpos, key : request
//            wr_en, wr_addr, wr_data                              : RAM write
//            out_valid, pixel, opaque                             : result
// Timing   : a request sampled at edge N appears on the outputs after N+2.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_bank #(
  parameter int    SIZE      = 4,
  parameter int    PIXW      = 6,
  parameter int    MAXW_LOG  = 2,
  parameter string INIT_FILE = "bitmap.txt"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [SIZE-1:0]       addr,
  input  logic [1:0]            wlog,
  input  logic                  hflip,
  input  logic                  vflip,
  input  logic [4+MAXW_LOG-1:0] hpos,
  input  logic [4:0]            vpos,
  input  logic [PIXW-1:0]       key,
  input  logic                  wr_en,
  input  logic [SIZE+8-1:0]     wr_addr,
  input  logic [PIXW-1:0]       wr_data,
  output logic                  out_valid,
  output logic [PIXW-1:0]       pixel,
  output logic                  opaque
);

  localparam int AW    = SIZE + 8;
  localparam int HW    = 4 + MAXW_LOG;
  // Column arithmetic must hold a row length of up to 128 (wlog = 3) as well
  // as any hpos value, so it is at least 8 bits wide.
  localparam int CW    = (HW + 1 > 8) ? HW + 1 : 8;
  localparam int DEPTH = 1 << AW;

  // --------------------------------------------------------------------------
  // Address generation and range check (combinational, request cycle)
  // --------------------------------------------------------------------------
  logic [CW-1:0] row_len;
  logic [CW-1:0] hpos_ext;
  logic [CW-1:0] hx;
  logic [4:0]    vy;
  logic [AW-1:0] mem_addr;
  logic          range_bad;

  always_comb begin
    row_len   = CW'(16) << wlog;
    hpos_ext  = CW'(hpos);
    // The range test always uses the unmirrored column.
    range_bad = (hpos_ext >= row_len) || (int'(wlog) > MAXW_LOG);
    hx        = hflip ? (row_len - hpos_ext - CW'(1)) : hpos_ext;
    // 31 - vpos on a 5-bit value is a plain inversion.
    vy        = vflip ? ~vpos : vpos;
    // Summing in AW bits discards the carry, so the last bitmap wraps into
    // block 0 exactly as the SIZE+9 bit sum truncated to AW bits would.
    mem_addr  = (AW'(addr) << 8) + ((AW'(vy) << 4) << wlog) + AW'(hx);
  end

  // --------------------------------------------------------------------------
  // Pixel RAM: not reset. The read is taken at the request edge, so a write
  // landing on the same edge returns the old word (read-first); a request on
  // the following edge sees the new word.
  // --------------------------------------------------------------------------
  logic [PIXW-1:0] ram [DEPTH];
  logic [PIXW-1:0] ram_rd_q;
  logic            wr_fire;

  // Writes are blocked while the block is held in reset.
  assign wr_fire = wr_en & rst_n;

  always_ff @(posedge clk) begin
    ram_rd_q <= ram[mem_addr];
    if (wr_fire) begin
      ram[wr_addr] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic            s1_valid_q,  s1_valid_d;
  logic            s1_bad_q,    s1_bad_d;
  logic [PIXW-1:0] s1_key_q,    s1_key_d;
  logic            s2_valid_q,  s2_valid_d;
  logic [PIXW-1:0] s2_pixel_q,  s2_pixel_d;
  logic            s2_opaque_q, s2_opaque_d;
  logic            out_valid_q, out_valid_d;
  logic [PIXW-1:0] pixel_q,     pixel_d;
  logic            opaque_q,    opaque_d;

  always_comb begin
    // Stage 1: capture request qualifiers; the key travels with its request.
    s1_valid_d  = req_valid;
    s1_bad_d    = range_bad;
    s1_key_d    = key;
    // Stage 2: mask out-of-range reads and evaluate transparency.
    s2_valid_d  = s1_valid_q;
    s2_pixel_d  = s1_bad_q ? '0 : ram_rd_q;
    s2_opaque_d = !s1_bad_q && (ram_rd_q != s1_key_q);
    // Output: pixel/opaque only change when a valid result arrives.
    out_valid_d = s2_valid_q;
    pixel_d     = s2_valid_q ? s2_pixel_q  : pixel_q;
    opaque_d    = s2_valid_q ? s2_opaque_q : opaque_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_bad_q    <= 1'b0;
      s1_key_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_pixel_q  <= '0;
      s2_opaque_q <= 1'b0;
      out_valid_q <= 1'b0;
      pixel_q     <= '0;
      opaque_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_bad_q    <= s1_bad_d;
      s1_key_q    <= s1_key_d;
      s2_valid_q  <= s2_valid_d;
      s2_pixel_q  <= s2_pixel_d;
      s2_opaque_q <= s2_opaque_d;
      out_valid_q <= out_valid_d;
      pixel_q     <= pixel_d;
      opaque_q    <= opaque_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pixel     = pixel_q;
  assign opaque    = opaque_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sprite_bank
// Purpose  : Self-checking bench for sprite_bank. Each request pushes its
//            expected pixel/opaque/arrival cycle onto a scoreboard; a monitor
//            pops and compares whenever out_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_bank;

  localparam int SIZE     = 4;
  localparam int PIXW     = 6;
  localparam int MAXW_LOG = 2;
  localparam int DEPTH    = 1 << (SIZE + 8);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic [SIZE-1:0]   addr = '0;
  logic [1:0]        wlog = '0;
  logic              hflip = 1'b0;
  logic              vflip = 1'b0;
  logic [5:0]        hpos = '0;
  logic [4:0]        vpos = '0;
  logic [PIXW-1:0]   key = '0;
  logic              wr_en = 1'b0;
  logic [SIZE+7:0]   wr_addr = '0;
  logic [PIXW-1:0]   wr_data = '0;
  logic              out_valid;
  logic [PIXW-1:0]   pixel;
  logic              opaque;

  sprite_bank #(
    .SIZE(SIZE), .PIXW(PIXW), .MAXW_LOG(MAXW_LOG), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .addr(addr),
    .wlog(wlog), .hflip(hflip), .vflip(vflip), .hpos(hpos), .vpos(vpos),
    .key(key), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .pixel(pixel), .opaque(opaque)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PIXW-1:0] pix;
    logic            op;
    int              due;
    int              id;
  } exp_t;

  exp_t            exp_q[$];
  logic [PIXW-1:0] model [DEPTH];
  int              cyc = 0;
  int              vectors = 0;
  int              miscompares = 0;
  int              next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: samples 1 ns after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid: out_valid=1 pixel=%h at cycle %0d, required no output", pixel, cyc);
        end else begin
          e = exp_q.pop_front();
          if (pixel !== e.pix || opaque !== e.op || cyc != e.due) begin
            miscompares++;
            $display("FAIL req%0d: got pixel=%h opaque=%b cycle=%0d, required pixel=%h opaque=%b cycle=%0d",
                     e.id, pixel, opaque, cyc, e.pix, e.op, e.due);
          end
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_req%0d: out_valid=%b at cycle %0d, required 1", e.id, out_valid, cyc);
      end
    end
  end

  // Drive one request for one cycle and record its expected result.
  task automatic send(input logic [SIZE-1:0] a, input logic [1:0] w,
                      input logic hf, input logic vf, input logic [5:0] hp,
                      input logic [4:0] vp, input logic [PIXW-1:0] k);
    exp_t e;
    int   len, hx, vy, m;
    bit   bad;
    @(negedge clk);
    req_valid = 1'b1; addr = a; wlog = w; hflip = hf; vflip = vf;
    hpos = hp; vpos = vp; key = k;
    len = 16 << int'(w);
    bad = (int'(hp) >= len) || (int'(w) > MAXW_LOG);
    hx  = hf ? len - 1 - int'(hp) : int'(hp);
    vy  = vf ? 31 - int'(vp) : int'(vp);
    m   = (int'(a) * 256 + vy * len + hx) & (DEPTH - 1);
    e.pix = bad ? '0 : model[m];
    e.op  = !bad && (e.pix != k);
    e.due = cyc + 3;   // sampled at edge cyc+1, visible after edge cyc+3
    e.id  = next_id++;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic load_ram();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = i[SIZE+7:0]; wr_data = i[PIXW-1:0];
      model[i] = i[PIXW-1:0];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    vectors++;
    if (pixel !== '0) begin miscompares++; $display("FAIL reset_pixel: got %h, required 00", pixel); end
    vectors++;
    if (opaque !== 1'b0) begin miscompares++; $display("FAIL reset_opaque: got %b, required 0", opaque); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain_check(input string name);
    idle(4);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_sequential();
    send(4'd1, 2'd0, 1'b0, 1'b0, 6'd3, 5'd2, 6'h00);   // 6'h23
    for (int h = 0; h < 16; h++) send(4'd1, 2'd0, 1'b0, 1'b0, h[5:0], 5'd2, 6'h00);
    drain_check("sequential");
  endtask

  task automatic test_width_mirror();
    send(4'd0, 2'd1, 1'b1, 1'b0, 6'd0, 5'd0, 6'h00);    // address 31
    send(4'd0, 2'd1, 1'b1, 1'b1, 6'd0, 5'd0, 6'h00);    // address 1023
    send(4'd2, 2'd2, 1'b1, 1'b0, 6'd5, 5'd3, 6'h00);
    send(4'd3, 2'd0, 1'b0, 1'b1, 6'd9, 5'd7, 6'h00);
    drain_check("width_mirror");
  endtask

  task automatic test_range_key();
    send(4'd0, 2'd0, 1'b0, 1'b0, 6'd20, 5'd0, 6'h00);   // hpos beyond row
    send(4'd0, 2'd0, 1'b0, 1'b0, 6'd16, 5'd0, 6'h00);   // first column out
    send(4'd0, 2'd0, 1'b0, 1'b0, 6'd15, 5'd0, 6'h00);   // last column in
    send(4'd0, 2'd0, 1'b1, 1'b0, 6'd20, 5'd0, 6'h00);   // mirrored, still out
    send(4'd0, 2'd3, 1'b0, 1'b0, 6'd1,  5'd0, 6'h00);   // width too large
    send(4'd1, 2'd2, 1'b0, 1'b0, 6'd63, 5'd31, 6'h00);  // widest, last pixel
    send(4'd0, 2'd0, 1'b0, 1'b0, 6'd5,  5'd1, 6'h15);   // word == key
    send(4'd0, 2'd0, 1'b0, 1'b0, 6'd5,  5'd1, 6'h00);   // key sampled per request
    drain_check("range_key");
  endtask

  task automatic test_wrap();
    send(4'd15, 2'd2, 1'b0, 1'b0, 6'd0,  5'd1,  6'h3F);
    send(4'd15, 2'd2, 1'b0, 1'b0, 6'd7,  5'd5,  6'h00);
    send(4'd15, 2'd2, 1'b1, 1'b1, 6'd0,  5'd0,  6'h00);
    drain_check("wrap");
  endtask

  task automatic test_write();
    // Address 300 = block 1, row 2, column 12.
    send(4'd1, 2'd0, 1'b0, 1'b0, 6'd12, 5'd2, 6'h00);
    wr_en = 1'b1; wr_addr = 12'd300; wr_data = 6'h2A;
    model[300] = 6'h2A;
    send(4'd1, 2'd0, 1'b0, 1'b0, 6'd12, 5'd2, 6'h00);
    wr_en = 1'b0;
    drain_check("write");
  endtask

  task automatic test_hold();
    send(4'd0, 2'd0, 1'b0, 1'b0, 6'd9, 5'd0, 6'h00);
    idle(5);
    vectors++;
    if (pixel !== 6'h09 || opaque !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold: got pixel=%h opaque=%b valid=%b, required 09 1 0", pixel, opaque, out_valid);
    end
    drain_check("hold");
  endtask

  task automatic test_back_to_back();
    logic [SIZE+7:0] wa;
    logic [PIXW-1:0] wd;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        send($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 31),
             $urandom_range(0, 63));
      else
        idle(1);
      if ($urandom_range(0, 4) == 0) begin
        wa = $urandom_range(0, DEPTH - 1);
        wd = $urandom_range(0, 63);
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
        model[wa] = wd;
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge clk);
    wr_en = 1'b0; req_valid = 1'b0;
    drain_check("back_to_back");
  endtask

  task automatic test_reset_midstream();
    logic [PIXW-1:0] old5;
    old5 = model[5];
    send(4'd0, 2'd0, 1'b0, 1'b0, 6'd1, 5'd0, 6'h00);
    send(4'd0, 2'd0, 1'b0, 1'b0, 6'd2, 5'd0, 6'h00);
    send(4'd0, 2'd0, 1'b0, 1'b0, 6'd3, 5'd0, 6'h00);
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_valid: got %b, required 1", out_valid); end
    rst_n = 1'b0;
    #1;
    exp_q.delete();   // two requests in flight are discarded
    vectors++;
    if (out_valid !== 1'b0 || pixel !== '0 || opaque !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%b pixel=%h opaque=%b, required 0 00 0", out_valid, pixel, opaque);
    end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 12'd5; wr_data = ~old5;   // must be ignored
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);   // the monitor flags any stale out_valid here
    send(4'd0, 2'd0, 1'b0, 1'b0, 6'd5, 5'd0, 6'h00);
    drain_check("reset_midstream");
  endtask

  initial begin
    test_reset();
    load_ram();
    test_sequential();
    test_width_mirror();
    test_range_key();
    test_wrap();
    test_write();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
